fifo_fwft: RTL and testbench

- Synchronous first-word-fall-through FIFO: the producer/consumer counterpart to the streaming DSP stages of the FM radio chain.
- Its read side supplies the exact dout/empty/rd_en contract the filter stages consume: data valid whenever empty=0, taken in the same cycle rd_en is asserted.
- Its write side accepts the wr_en/full contract the filter stages drive.
- One instance sits between every pair of adjacent stages (demod -> de-emphasis IIR -> decimating FIR -> audio out).

---
 rtl/radio_pkg.sv | 14 +
 rtl/fifo_mem.sv | 30 +++
 rtl/fifo_fwft.sv | 95 +++++++++
 tb/tb_fifo_fwft.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// Shared FM-radio project package: constants and helpers every streaming stage
// and FIFO instance agrees on.
package radio_pkg;

    localparam int FIFO_DATA_WIDTH_DEFAULT    = 32;
    localparam int FIFO_BUFFER_SIZE_DEFAULT   = 16;
    localparam int ALMOST_FULL_THRESH_DEFAULT = 12;

    // Pointer width for a power-of-two FIFO depth.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write port, asynchronous read port.
module fifo_mem
    import radio_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = FIFO_BUFFER_SIZE_DEFAULT,
    parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would cost a mux per bit and
    // nothing downstream reads a slot before it has been written.
    // NOTE: sequential state uses <= so every reader of mem sees the pre-edge value.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through synchronous FIFO linking adjacent DSP stages:
// head word is valid on dout whenever empty=0 and is popped by rd_en in that cycle.
module fifo_fwft
    import radio_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH    = FIFO_DATA_WIDTH_DEFAULT,
    parameter int FIFO_BUFFER_SIZE   = FIFO_BUFFER_SIZE_DEFAULT,
    parameter int ALMOST_FULL_THRESH = ALMOST_FULL_THRESH_DEFAULT
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0]            din,
    output logic                                  full,
    output logic                                  almost_full,
    input  logic                                  rd_en,
    output logic [FIFO_DATA_WIDTH-1:0]            dout,
    output logic                                  empty,
    output logic [addr_width(FIFO_BUFFER_SIZE):0] level,
    output logic                                  overflow,
    output logic                                  underflow
);

    localparam int ADDR_W  = addr_width(FIFO_BUFFER_SIZE);
    localparam int LEVEL_W = ADDR_W + 1;

    logic [ADDR_W-1:0]          wr_ptr;
    logic [ADDR_W-1:0]          rd_ptr;
    logic [LEVEL_W-1:0]         count;
    logic [LEVEL_W-1:0]         count_next;
    logic                       wr_accept;
    logic                       rd_accept;
    logic [FIFO_DATA_WIDTH-1:0] head;

    // Flags come straight from the registered count, so they never glitch on
    // same-cycle requests.
    assign empty       = (count == '0);
    assign full        = (count == LEVEL_W'(FIFO_BUFFER_SIZE));
    assign almost_full = (count >= LEVEL_W'(ALMOST_FULL_THRESH));
    assign level       = count;

    assign wr_accept = wr_en & ~full;
    assign rd_accept = rd_en & ~empty;

    fifo_mem #(
        .DATA_WIDTH (FIFO_DATA_WIDTH),
        .DEPTH      (FIFO_BUFFER_SIZE),
        .ADDR_WIDTH (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (wr_accept & ~reset),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Uninitialised storage is masked while empty so dout reads zero out of reset.
    assign dout = empty ? '0 : head;

    // NOTE: count_next gets a default first so no path through the block infers a latch.
    always_comb begin
        count_next = count;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = count + LEVEL_W'(1);
            2'b01:   count_next = count - LEVEL_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_fwft.sv
// Directed bench for fifo_fwft: reset, fall-through, fill/drain, pointer wrap,
// simultaneous requests and mid-stream reset.
module tb_fifo_fwft;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] din;
    logic        full;
    logic        almost_full;
    logic        rd_en;
    logic [31:0] dout;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_fwft #(
        .FIFO_DATA_WIDTH    (32),
        .FIFO_BUFFER_SIZE   (16),
        .ALMOST_FULL_THRESH (12)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (wr_en),
        .din         (din),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .dout        (dout),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land 1 time unit after the edge for sampling/driving.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic e, input logic f,
                               input logic af, input int lvl, input logic ovf, input logic unf);
        check({tag, ".empty"},       32'(empty),       32'(e));
        check({tag, ".full"},        32'(full),        32'(f));
        check({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        check({tag, ".level"},       32'(level),       32'(lvl));
        check({tag, ".overflow"},    32'(overflow),    32'(ovf));
        check({tag, ".underflow"},   32'(underflow),   32'(unf));
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        step();
        step();
        check_flags("reset", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("reset.dout", dout, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step();
            check_flags($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end

        // Single-word fall-through and pop.
        wr_en = 1'b1; din = 32'h000000B2;
        step();
        wr_en = 1'b0;
        check("single.dout", dout, 32'h000000B2);
        check_flags("single_wr", 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check_flags("single_rd", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 32'(i);
            step();
            check($sformatf("fill%0d.level", i), 32'(level), 32'(i + 1));
            check($sformatf("fill%0d.af", i), 32'(almost_full), 32'(i + 1 >= 12));
            check($sformatf("fill%0d.full", i), 32'(full), 32'(i + 1 == 16));
        end
        din = 32'd99;
        step();
        wr_en = 1'b0;
        check_flags("overflow", 1'b0, 1'b1, 1'b1, 16, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d.dout", i), dout, 32'(i));
            check($sformatf("drain%0d.empty", i), 32'(empty), 32'h0);
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check_flags("drained", 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Pointer wrap: pointers start at 1, so 10+10 words cross index 15 -> 0.
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; din = 32'(200 + i);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pre_wrap%0d.dout", i), dout, 32'(200 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; din = 32'(100 + i);
            step();
        end
        wr_en = 1'b0;
        check("wrap.level", 32'(level), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrap%0d.dout", i), dout, 32'(100 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check("wrap.empty", 32'(empty), 32'h1);

        // Steady-state streaming at level 5.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = 32'(300 + i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 32'(305 + k);
            check($sformatf("stream%0d.dout", k), dout, 32'(300 + k));
            step();
            check($sformatf("stream%0d.level", k), 32'(level), 32'd5);
        end
        rd_en = 1'b0;

        // Queue holds 320..324; top up to full with 325..335.
        for (int i = 0; i < 11; i++) begin
            wr_en = 1'b1; din = 32'(325 + i);
            step();
        end
        check("topup.full", 32'(full), 32'h1);
        wr_en = 1'b1; rd_en = 1'b1; din = 32'd999;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_flags("full_both", 1'b0, 1'b0, 1'b1, 15, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("full_drain%0d.dout", i), dout, 32'(321 + i));
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        check("full_drain.empty", 32'(empty), 32'h1);

        // Empty with both requests: write wins, read flagged.
        wr_en = 1'b1; rd_en = 1'b1; din = 32'h55;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check_flags("empty_both", 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
        check("empty_both.dout", dout, 32'h55);

        // Mid-stream reset at level 7 with a concurrent write.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; din = 32'(400 + i);
            step();
        end
        wr_en = 1'b0;
        check("pre_reset.level", 32'(level), 32'd7);
        reset = 1'b1; wr_en = 1'b1; din = 32'hDEAD;
        step();
        reset = 1'b0; wr_en = 1'b0;
        check_flags("mid_reset", 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        wr_en = 1'b1; din = 32'hFFFFFD66;
        step();
        wr_en = 1'b0;
        check("post_reset.dout", dout, 32'hFFFFFD66);
        check_flags("post_reset", 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
